// File: rtl/pc_redirect.sv
// Fetch-PC generator with EX-stage redirect handling.
// Tracks the fetch address and turns taken branches, JAL and JALR in EX into
// a one-cycle pipeline flush. A misaligned taken target parks the block in
// HALT with a trap pulse until the next reset.
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_trap,
    output logic [31:0] trap_pc,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic        r_pcValid;
    logic        r_flush;
    logic        r_trap;
    logic [31:0] r_trapPc;
    logic [15:0] r_count;

    logic [31:0] w_seqTarget;
    logic [31:0] w_jalrTarget;
    logic [31:0] w_target;
    logic        w_taken;
    logic [31:0] w_nextPc;
    logic [31:0] w_nextTrapPc;
    logic [15:0] w_nextCount;
    logic        w_nextTrap;

    // Redirect target and taken decision; JALR wins over JAL, which shares the branch adder.
    always_comb begin
        w_seqTarget  = ex_pc + ex_imm;
        w_jalrTarget = (ex_rs1 + ex_imm) & ~32'h1;
        w_target     = ex_is_jalr ? w_jalrTarget : w_seqTarget;
        w_taken      = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch));
    end

    // Next-state and next-register values; pc only advances once a valid fetch has been presented.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_nextTrapPc = r_trapPc;
        w_nextCount  = r_count;
        w_nextTrap   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_taken) begin
                    if (w_target[1:0] == 2'b00) begin
                        w_nextState = FLUSH;
                        w_nextPc    = w_target;
                        w_nextCount = r_count + 16'd1;
                    end else begin
                        w_nextState  = HALT;
                        w_nextTrap   = 1'b1;
                        w_nextTrapPc = ex_pc;
                    end
                end else if (!stall && imem_ready && r_pcValid) begin
                    w_nextPc = r_pc + 32'd4;
                end
            end
            FLUSH: begin
                w_nextState = RUN;
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // State and registered outputs; reset clears every flag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_pcValid <= 1'b0;
            r_flush   <= 1'b0;
            r_trap    <= 1'b0;
            r_trapPc  <= 32'h0;
            r_count   <= 16'h0;
        end else begin
            r_state   <= w_nextState;
            r_pc      <= w_nextPc;
            r_pcValid <= (w_nextState == RUN);
            r_flush   <= (w_nextState != RUN);
            r_trap    <= w_nextTrap;
            r_trapPc  <= w_nextTrapPc;
            r_count   <= w_nextCount;
        end
    end

    assign pc             = r_pc;
    assign pc_valid       = r_pcValid;
    assign flush_if_id    = r_flush;
    assign flush_id_ex    = r_flush;
    assign misalign_trap  = r_trap;
    assign trap_pc        = r_trapPc;
    assign redirect_count = r_count;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect with an expected-result scoreboard queue.
module tb_pc_redirect;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        imem_ready;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_trap;
    logic [31:0] trap_pc;
    logic [15:0] redirect_count;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        trap;
        logic [31:0] trapPc;
        logic [15:0] count;
    } expect_t;

    expect_t scoreboard[$];
    int      assertCount = 0;
    int      failCount   = 0;

    pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .imem_ready     (imem_ready),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_trap  (misalign_trap),
        .trap_pc        (trap_pc),
        .redirect_count (redirect_count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic vld, input logic isBr, input logic isJal,
                                 input logic isJalr, input logic br, input logic [31:0] exPc,
                                 input logic [31:0] exImm, input logic [31:0] exRs1,
                                 input logic stl, input logic rdy);
        ex_valid     = vld;
        ex_is_branch = isBr;
        ex_is_jal    = isJal;
        ex_is_jalr   = isJalr;
        ex_branch    = br;
        ex_pc        = exPc;
        ex_imm       = exImm;
        ex_rs1       = exRs1;
        stall        = stl;
        imem_ready   = rdy;
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] ePc, input logic eValid,
                              input logic eFlush, input logic eTrap, input logic [31:0] eTrapPc,
                              input logic [15:0] eCount);
        expect_t e;
        e.tag    = tag;
        e.pc     = ePc;
        e.valid  = eValid;
        e.flush  = eFlush;
        e.trap   = eTrap;
        e.trapPc = eTrapPc;
        e.count  = eCount;
        scoreboard.push_back(e);
    endtask

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        if (scoreboard.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
        end else begin
            e = scoreboard.pop_front();
            checkField(e.tag, "pc",             pc,                     e.pc);
            checkField(e.tag, "pc_valid",       {31'h0, pc_valid},      {31'h0, e.valid});
            checkField(e.tag, "flush_if_id",    {31'h0, flush_if_id},   {31'h0, e.flush});
            checkField(e.tag, "flush_id_ex",    {31'h0, flush_id_ex},   {31'h0, e.flush});
            checkField(e.tag, "misalign_trap",  {31'h0, misalign_trap}, {31'h0, e.trap});
            checkField(e.tag, "trap_pc",        trap_pc,                e.trapPc);
            checkField(e.tag, "redirect_count", {16'h0, redirect_count}, {16'h0, e.count});
        end
    endtask

    task automatic clockAndCheck();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Directed sequence: every step drives inputs, queues its expectation, then checks after the edge.
    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        #3;
        pushExpect("reset", 32'h0, 0, 0, 0, 32'h0, 16'd0);
        checkOutput();

        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] sequential fetch");
        pushExpect("seq0", 32'h0, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();
        pushExpect("seq1", 32'h4, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();
        pushExpect("seq2", 32'h8, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();
        pushExpect("seq3", 32'hC, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();

        $display("[TB] taken BEQ under stall");
        applyStimulus(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'h0, 1, 1);
        pushExpect("beq_taken", 32'h120, 0, 1, 0, 32'h0, 16'd1); clockAndCheck();
        applyStimulus(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'h0, 0, 1);
        pushExpect("flush_ignores_ex", 32'h120, 1, 0, 0, 32'h0, 16'd1); clockAndCheck();

        $display("[TB] not-taken branch, stall, imem not ready, ex_valid low");
        applyStimulus(1, 1, 0, 0, 0, 32'h100, 32'h20, 32'h0, 0, 1);
        pushExpect("beq_not_taken", 32'h124, 1, 0, 0, 32'h0, 16'd1); clockAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
        pushExpect("stall_hold", 32'h124, 1, 0, 0, 32'h0, 16'd1); clockAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        pushExpect("not_ready_hold", 32'h124, 1, 0, 0, 32'h0, 16'd1); clockAndCheck();
        applyStimulus(0, 1, 1, 1, 1, 32'h100, 32'h20, 32'h0, 0, 1);
        pushExpect("ex_invalid", 32'h128, 1, 0, 0, 32'h0, 16'd1); clockAndCheck();

        $display("[TB] JALR with imem not ready");
        applyStimulus(1, 0, 0, 1, 0, 32'h100, 32'h4, 32'h2001, 0, 0);
        pushExpect("jalr", 32'h2004, 0, 1, 0, 32'h0, 16'd2); clockAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        pushExpect("jalr_run", 32'h2004, 1, 0, 0, 32'h0, 16'd2); clockAndCheck();

        $display("[TB] priority JALR > JAL > branch");
        applyStimulus(1, 1, 1, 1, 1, 32'h500, 32'h8, 32'h3001, 0, 1);
        pushExpect("prio_jalr", 32'h3008, 0, 1, 0, 32'h0, 16'd3); clockAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        pushExpect("prio_jalr_run", 32'h3008, 1, 0, 0, 32'h0, 16'd3); clockAndCheck();
        applyStimulus(1, 1, 1, 0, 0, 32'h600, 32'h10, 32'h7777, 0, 1);
        pushExpect("prio_jal", 32'h610, 0, 1, 0, 32'h0, 16'd4); clockAndCheck();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        pushExpect("prio_jal_run", 32'h610, 1, 0, 0, 32'h0, 16'd4); clockAndCheck();

        $display("[TB] reset during FLUSH");
        applyStimulus(1, 0, 1, 0, 0, 32'h300, 32'h10, 32'h0, 0, 1);
        pushExpect("jal_pre_reset", 32'h310, 0, 1, 0, 32'h0, 16'd5); clockAndCheck();
        rst_n = 1'b0;
        #1;
        pushExpect("reset_in_flush", 32'h0, 0, 0, 0, 32'h0, 16'd0); checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        pushExpect("post_reset0", 32'h0, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();
        pushExpect("post_reset1", 32'h4, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();

        $display("[TB] misaligned JAL into HALT");
        applyStimulus(1, 0, 1, 0, 0, 32'h40, 32'h6, 32'h0, 0, 1);
        pushExpect("misalign", 32'h4, 0, 1, 1, 32'h40, 16'd0); clockAndCheck();
        applyStimulus(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            pushExpect($sformatf("halt%0d", i), 32'h4, 0, 1, 0, 32'h40, 16'd0);
            clockAndCheck();
        end
        rst_n = 1'b0;
        #1;
        pushExpect("reset_in_halt", 32'h0, 0, 0, 0, 32'h0, 16'd0); checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        pushExpect("halt_exit", 32'h0, 1, 0, 0, 32'h0, 16'd0); clockAndCheck();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC (hazard stall).
- imem_ready  input  1  fetch accepts current pc this cycle.
- ex_valid  input  1  EX-stage instruction valid.
- ex_is_branch  input  1  EX instruction is conditional branch.
- ex_is_jal  input  1  EX instruction is JAL.
- ex_is_jalr  input  1  EX instruction is JALR.
- ex_branch  input  1  branch-condition result from branch comparator.
- ex_pc  input  32  PC of EX instruction.
- ex_imm  input  32  sign-extended immediate of EX instruction.
- ex_rs1  input  32  forwarded rs1 value.
- pc  output  32  current fetch address.
- pc_valid  output  1  pc is a valid fetch request.
- flush_if_id  output  1  squash IF/ID register.
- flush_id_ex  output  1  squash ID/EX register.
- misalign_trap  output  1  one-cycle pulse on misaligned taken target.
- trap_pc  output  32  ex_pc of the trapping instruction.
- redirect_count  output  16  number of redirects taken.

Function
REQ-003 The block SHALL implement three states: RUN, FLUSH, HALT.
REQ-004 The block SHALL compute target = ex_pc + ex_imm for branch and JAL, and target = (ex_rs1 + ex_imm) & ~32'h1 for JALR, using 32-bit arithmetic with wrap-around and no overflow detection.
REQ-005 The block SHALL compute taken = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch)), evaluated only in RUN.
REQ-006 In RUN with taken and target[1:0] == 2'b00, the block SHALL load pc <= target at the next edge, enter FLUSH, and increment redirect_count modulo 2^16.
REQ-007 Redirect SHALL take priority over stall and over imem_ready == 0.
REQ-008 In FLUSH, which lasts exactly one cycle, the block SHALL drive flush_if_id = 1, flush_id_ex = 1 and pc_valid = 0; ignore all ex_* inputs; hold pc; and return to RUN.
REQ-009 In RUN with taken and target[1:0] != 2'b00, the block SHALL:
- enter HALT;
- pulse misalign_trap for exactly one cycle (the first HALT cycle);
- latch trap_pc <= ex_pc;
- keep pc unchanged;
- not increment redirect_count.
REQ-010 In HALT, the block SHALL hold pc_valid = 0, flush_if_id = 1 and flush_id_ex = 1, and SHALL exit only by reset.
REQ-011 In RUN with no taken, stall == 0 and imem_ready == 1, the block SHALL set pc <= pc + 4; otherwise pc SHALL hold.
REQ-012 In RUN, the block SHALL drive pc_valid = 1 and flush_if_id = flush_id_ex = 0.
REQ-013 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.
REQ-014 With ex_valid == 0, the block SHALL ignore the ex_is_* and ex_branch inputs.
REQ-015 With more than one ex_is_* input set simultaneously, JALR SHALL take priority over JAL, and JAL over branch.

Reset
REQ-016 On rst_n == 0, the block SHALL immediately drive:
- pc = RESET_PC, pc_valid = 0;
- state = RUN, effective from the first edge after deassertion;
- flush_if_id = 0, flush_id_ex = 0;
- misalign_trap = 0;
- trap_pc = 0;
- redirect_count = 0.
REQ-017 pc_valid SHALL rise at the first rising clk edge after rst_n deasserts.
REQ-018 Reset asserted in FLUSH or HALT SHALL abort that state with no residual flush or trap pulse.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Sequential fetch: after reset, imem_ready = 1, stall = 0 for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC.
- Taken BEQ: ex_pc = 0x100, ex_imm = 0x20, ex_is_branch = 1, ex_branch = 1, with stall = 1 -> pc = 0x120 next cycle; one FLUSH cycle with flush_* = 1 and pc_valid = 0; redirect_count = 1.
- Not-taken branch: ex_branch = 0 -> no flush, pc advances by 4, redirect_count unchanged.
- JALR: ex_rs1 = 0x2001, ex_imm = 0x4 -> pc = 0x2004 (bit 0 cleared).
- Misaligned JAL: ex_pc = 0x40, ex_imm = 0x6 -> misalign_trap pulses once, trap_pc = 0x40, pc_valid stays 0 and flush_* stay 1 for 10 cycles until reset.
- Reset during FLUSH: rst_n low mid-FLUSH -> pc = RESET_PC and all flags 0 immediately, before the next edge.
